atten_ramp: RTL and testbench

- Upstream neighbour of the 13-band equalizer filter: produces the 13 attenuation gains it consumes.
- MicroBlaze writes per-band target gains over the simple bus decoded from AXI4-Lite (wr/rd/wrAddr/wrData/rdAddr/rdData).
- Block ramps each live gain toward its target once per audio sample tick, which suppresses zipper noise when sliders move.
- Gains are signed Q1.14; unity = 16'h4000.

---
 rtl/atten_ramp.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_atten_ramp.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atten_ramp.sv
// -----------------------------------------------------------------------------
// atten_ramp
//
// Produces the 13 per-band attenuation gains consumed by the equalizer filter.
// Software writes per-band target gains over a simple register bus. Once per
// audio sample tick, every live gain is moved one step toward its target,
// one band per clock, which suppresses zipper noise when sliders move.
// Gains are signed Q1.14 (unity = 16'h4000).
//
// Build option:
//   ATTEN_RAMP_EXP_EN  defined   -> exponential glide: step = max(1, |diff| >> STEP[3:0])
//                      undefined -> linear glide: step = STEP[14:0]
//
// Ports:
//   S_AXI_ACLK    in   clock
//   S_AXI_ARESET  in   asynchronous active-high reset
//   wr            in   single-cycle write strobe
//   wrAddr        in   write word address
//   wrData        in   write data
//   rd            in   read strobe
//   rdAddr        in   read word address
//   rdData        out  read data, combinational, 0 when rd is low
//   sample_tick   in   one-cycle pulse per audio sample
//   atten_out     out  current gains, band k at [16k+15:16k]
//   settled       out  all current gains equal their targets (registered)
//   busy          out  ramp scan in progress
//
// Register map (word address):
//   0..12   TARGET[k]  rw, 16-bit signed, reads sign-extended
//   16      STEP       rw, [14:0]; 0 freezes linear ramping
//   17      CTRL       bit0 EN (stored), bit1 SNAP (write-1 pulse, reads 0)
//   18      STATUS     ro: bit0 busy, bit1 settled, [15:8] overrun count;
//                      any write clears the overrun count
//   32..44  CUR[k]     ro, sign-extended
// -----------------------------------------------------------------------------
module atten_ramp #(
    parameter int          NUM_BANDS          = 13,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter logic [15:0] GAIN_RESET         = 16'h4000,
    parameter logic [15:0] STEP_RESET         = 16'h0100
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic                            wr,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   wrAddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   wrData,
    input  logic                            rd,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   rdAddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   rdData,
    input  logic                            sample_tick,
    output logic [NUM_BANDS*16-1:0]         atten_out,
    output logic                            settled,
    output logic                            busy
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

    localparam int ADDR_STEP     = 16;
    localparam int ADDR_CTRL     = 17;
    localparam int ADDR_STATUS   = 18;
    localparam int ADDR_CUR_BASE = 32;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             pending;
    logic [7:0]       overrun;
    logic             en;
    logic [14:0]      step;
    logic [15:0]      target [NUM_BANDS];
    logic [15:0]      cur    [NUM_BANDS];

    // ------------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------------
    logic             tgt_wr [NUM_BANDS];
    logic             step_wr;
    logic             ctrl_wr;
    logic             status_wr;
    logic             snap;
    logic             unused_wr_bits;

    always_comb begin
        for (int unsigned k = 0; k < NUM_BANDS; k++) begin
            tgt_wr[k] = wr && (wrAddr == AW'(k));
        end
    end

    assign step_wr   = wr && (wrAddr == AW'(ADDR_STEP));
    assign ctrl_wr   = wr && (wrAddr == AW'(ADDR_CTRL));
    assign status_wr = wr && (wrAddr == AW'(ADDR_STATUS));
    assign snap      = ctrl_wr && wrData[1];

    assign unused_wr_bits = ^wrData[DW-1:16];

    // ------------------------------------------------------------------------
    // Software-owned registers
    // ------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                target[k] <= GAIN_RESET;
            end
            step <= STEP_RESET[14:0];
            en   <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                if (tgt_wr[k]) begin
                    target[k] <= wrData[15:0];
                end
            end
            if (step_wr) begin
                step <= wrData[14:0];
            end
            if (ctrl_wr) begin
                en <= wrData[0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-band update for the band currently selected by idx. The target is
    // read from the register before any same-cycle write lands, so a write
    // racing the update of its own band is seen only on the next tick.
    // ------------------------------------------------------------------------
    logic [15:0] sel_tgt;
    logic [15:0] sel_cur;
    logic [16:0] diff;
    logic [16:0] mag;
    logic [15:0] delta;
    logic [15:0] upd;

    assign sel_tgt = target[idx];
    assign sel_cur = cur[idx];

    always_comb begin
        // 17-bit difference: the full Q1.14 range spans more than 16 bits
        diff  = {sel_tgt[15], sel_tgt} - {sel_cur[15], sel_cur};
        mag   = diff[16] ? (17'd0 - diff) : diff;
`ifdef ATTEN_RAMP_EXP_EN
        delta = 16'(mag >> step[3:0]);
        if (delta == 16'd0) begin
            delta = 16'd1;
        end
`else
        delta = {1'b0, step};
`endif
        if (mag <= {1'b0, delta}) begin
            upd = sel_tgt;
        end else if (!diff[16]) begin
            upd = sel_cur + delta;
        end else begin
            upd = sel_cur - delta;
        end
    end

    // ------------------------------------------------------------------------
    // Scan FSM, current gains, tick bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            pending <= 1'b0;
            overrun <= '0;
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                cur[k] <= GAIN_RESET;
            end
        end else begin
            if (snap) begin
                // SNAP wins over everything: jump, abort scan, drop ticks
                for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                    cur[k] <= target[k];
                end
                state   <= IDLE;
                idx     <= '0;
                busy    <= 1'b0;
                pending <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (en && (sample_tick || pending)) begin
                            state   <= SCAN;
                            idx     <= '0;
                            busy    <= 1'b1;
                            pending <= 1'b0;
                        end else if (!en) begin
                            pending <= 1'b0;
                        end
                    end
                    SCAN: begin
                        cur[idx] <= upd;
                        if (!en) begin
                            pending <= 1'b0;
                        end else if (sample_tick) begin
                            if (!pending) begin
                                pending <= 1'b1;
                            end else if (overrun != 8'hFF) begin
                                overrun <= overrun + 8'd1;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            idx   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
            // Clear has priority over a same-cycle overrun increment
            if (status_wr) begin
                overrun <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Settled flag, one cycle behind the registers it compares
    // ------------------------------------------------------------------------
    logic all_eq;

    always_comb begin
        all_eq = 1'b1;
        for (int unsigned k = 0; k < NUM_BANDS; k++) begin
            if (cur[k] != target[k]) begin
                all_eq = 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            settled <= 1'b1;
        end else begin
            settled <= all_eq;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        atten_out = '0;
        for (int unsigned k = 0; k < NUM_BANDS; k++) begin
            atten_out[16*k +: 16] = cur[k];
        end
    end

    always_comb begin
        rdData = '0;
        if (rd) begin
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                if (rdAddr == AW'(k)) begin
                    rdData = DW'(signed'(target[k]));
                end
                if (rdAddr == AW'(ADDR_CUR_BASE + k)) begin
                    rdData = DW'(signed'(cur[k]));
                end
            end
            if (rdAddr == AW'(ADDR_STEP)) begin
                rdData = DW'({1'b0, step});
            end
            if (rdAddr == AW'(ADDR_CTRL)) begin
                rdData = DW'({1'b0, en});
            end
            if (rdAddr == AW'(ADDR_STATUS)) begin
                rdData = DW'({overrun, 6'd0, settled, busy});
            end
        end
    end

endmodule

// File: tb/tb_atten_ramp.sv
// -----------------------------------------------------------------------------
// tb_atten_ramp
//
// Directed bench for atten_ramp (default linear build). Inputs are driven on
// the falling edge and outputs are sampled on the falling edge, half a cycle
// away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_atten_ramp;

    localparam int NB = 13;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              wr      = 1'b0;
    logic              rd      = 1'b0;
    logic              tick    = 1'b0;
    logic [5:0]        wr_addr = '0;
    logic [5:0]        rd_addr = '0;
    logic [31:0]       wr_data = '0;
    logic [31:0]       rd_data;
    logic [NB*16-1:0]  atten;
    logic              settled;
    logic              busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    atten_ramp #(
        .NUM_BANDS          (NB),
        .C_S_AXI_ADDR_WIDTH (6),
        .C_S_AXI_DATA_WIDTH (32),
        .GAIN_RESET         (16'h4000),
        .STEP_RESET         (16'h0100)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .wr           (wr),
        .wrAddr       (wr_addr),
        .wrData       (wr_data),
        .rd           (rd),
        .rdAddr       (rd_addr),
        .rdData       (rd_data),
        .sample_tick  (tick),
        .atten_out    (atten),
        .settled      (settled),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] band(input int k);
        return atten[16*k +: 16];
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [5:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr      = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr      = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] addr, output logic [31:0] data);
        rd      = 1'b1;
        rd_addr = addr;
        #1;
        data    = rd_data;
        rd      = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [15:0] exp_band [NB];

        // ---------------- reset state ----------------
        cycles(2);
        rst = 1'b0;
        cycles(1);
        for (int k = 0; k < NB; k++) begin
            check($sformatf("reset_band%0d", k), 32'(band(k)), 32'h4000);
        end
        check("reset_settled", 32'(settled), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        bus_read(6'd18, r);
        check("reset_status", r, 32'h0000_0002);
        bus_read(6'd16, r);
        check("reset_step", r, 32'h0000_0100);
        bus_read(6'd20, r);
        check("undef_read", r, 32'h0);
        rd_addr = 6'd18;
        #1;
        check("rd_low_zero", rd_data, 32'h0);

        // ---------------- linear ramp on band 3 ----------------
        bus_write(6'd3, 32'h0000_1000);
        bus_write(6'd16, 32'h0000_0400);
        bus_write(6'd17, 32'h0000_0001);
        for (int i = 1; i <= 12; i++) begin
            pulse_tick();
            if (i < 12) begin
                cycles(19);
                check($sformatf("ramp_tick%0d", i), 32'(band(3)), 32'h4000 - 32'(i) * 32'h400);
                if (i == 11) begin
                    check("ramp_settled_before", 32'(settled), 32'd0);
                end
            end else begin
                cycles(3);
                check("ramp_last_pre", 32'(band(3)), 32'h1400);
                check("ramp_settled_pre", 32'(settled), 32'd0);
                cycles(1);
                check("ramp_last_post", 32'(band(3)), 32'h1000);
                cycles(1);
                check("ramp_settled_post", 32'(settled), 32'd1);
                cycles(15);
            end
        end
        for (int k = 0; k < NB; k++) begin
            if (k != 3) begin
                check($sformatf("ramp_other%0d", k), 32'(band(k)), 32'h4000);
            end
        end
        bus_read(6'd35, r);
        check("ramp_cur3_read", r, 32'h0000_1000);

        // ---------------- 17-bit diff, max step ----------------
        bus_write(6'd0, 32'h0000_C000);
        bus_write(6'd16, 32'h0000_7FFF);
        pulse_tick();
        cycles(19);
        check("bigstep_first", 32'(band(0)), 32'h0000_C001);
        check("bigstep_unsettled", 32'(settled), 32'd0);
        bus_read(6'd32, r);
        check("bigstep_cur0_read", r, 32'hFFFF_C001);
        pulse_tick();
        cycles(19);
        check("bigstep_second", 32'(band(0)), 32'h0000_C000);
        bus_read(6'd0, r);
        check("target0_read", r, 32'hFFFF_C000);
        check("bigstep_settled", 32'(settled), 32'd1);

        // ---------------- overrun: 4 ticks, 2-cycle spacing ----------------
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
        end
        cycles(6);
        check("ovr_scan1_busy", 32'(busy), 32'd1);
        cycles(1);
        check("ovr_scan1_end", 32'(busy), 32'd0);
        cycles(1);
        check("ovr_pending_scan", 32'(busy), 32'd1);
        cycles(13);
        check("ovr_scan2_end", 32'(busy), 32'd0);
        cycles(3);
        check("ovr_no_third", 32'(busy), 32'd0);
        bus_read(6'd18, r);
        check("ovr_status", r, 32'h0000_0202);
        bus_write(6'd18, 32'h0);
        bus_read(6'd18, r);
        check("ovr_cleared", r, 32'h0000_0002);

        // ---------------- SNAP mid-scan ----------------
        bus_write(6'd5, 32'h0);
        bus_write(6'd16, 32'h1);
        pulse_tick();
        cycles(3);
        check("snap_pre_busy", 32'(busy), 32'd1);
        check("snap_pre_band5", 32'(band(5)), 32'h4000);
        bus_write(6'd17, 32'h3);
        check("snap_busy", 32'(busy), 32'd0);
        check("snap_band5", 32'(band(5)), 32'h0);
        cycles(1);
        check("snap_settled", 32'(settled), 32'd1);
        for (int k = 0; k < NB; k++) begin
            exp_band[k] = 16'h4000;
        end
        exp_band[0] = 16'hC000;
        exp_band[3] = 16'h1000;
        exp_band[5] = 16'h0000;
        for (int k = 0; k < NB; k++) begin
            check($sformatf("snap_band%0d", k), 32'(band(k)), 32'(exp_band[k]));
        end
        cycles(20);
        check("snap_stays_idle", 32'(busy), 32'd0);

        // ---------------- async reset mid-scan ----------------
        bus_write(6'd1, 32'h0000_2000);
        bus_write(6'd16, 32'h0000_0100);
        pulse_tick();
        cycles(2);
        check("arst_pre_band1", 32'(band(1)), 32'h3F00);
        check("arst_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < NB; k++) begin
            check($sformatf("arst_band%0d", k), 32'(band(k)), 32'h4000);
        end
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_settled", 32'(settled), 32'd1);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            cycles(3);
            check($sformatf("en0_busy%0d", i), 32'(busy), 32'd0);
        end
        for (int k = 0; k < NB; k++) begin
            check($sformatf("en0_band%0d", k), 32'(band(k)), 32'h4000);
        end
        bus_read(6'd1, r);
        check("arst_target1", r, 32'h0000_4000);
        bus_read(6'd17, r);
        check("arst_ctrl", r, 32'h0);
        bus_read(6'd18, r);
        check("arst_status", r, 32'h0000_0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
